sfx_sequencer: RTL and testbench

Sound-effect scheduler for the Pong audio path. It accepts one-cycle event pulses from game logic (paddle hit, border hit, win) and arbitrates between them by priority. It steps the 8-bit beat index that drives the tone lookup (Music) through each effect's beat range at a fixed beat rate. Index 0 is silence and is driven whenever no effect is playing.

---
 rtl/sfx_sequencer.sv | 164 ++++++++++++++++
 tb/tb_sfx_sequencer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/sfx_sequencer.sv
// Sound-effect sequencer: arbitrates paddle/border/win event pulses by
// priority and steps the Music beat index through each effect's range,
// holding every index for BEAT_DIV clock cycles. Index 0 means silence.
module sfx_sequencer #(
  parameter int unsigned BEAT_DIV     = 32'd12500000,
  parameter logic [7:0]  PADDLE_FIRST = 8'd1,
  parameter logic [7:0]  PADDLE_LAST  = 8'd5,
  parameter logic [7:0]  BORDER_FIRST = 8'd6,
  parameter logic [7:0]  BORDER_LAST  = 8'd7,
  parameter logic [7:0]  WIN_FIRST    = 8'd8,
  parameter logic [7:0]  WIN_LAST     = 8'd13
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       paddle_req,
  input  logic       border_req,
  input  logic       win_req,
  input  logic       mute,
  output logic [7:0] beat_num,
  output logic       busy,
  output logic [1:0] active_sfx
);

  // class codes double as priority: 3 win > 2 border > 1 paddle > 0 none
  typedef enum logic {IDLE, PLAY} state_t;

  state_t      state_q, state_d;
  logic [7:0]  beat_q, beat_d;
  logic [1:0]  act_q, act_d;
  logic [2:0]  pend_q, pend_d;   // bit0 paddle, bit1 border, bit2 win
  logic [31:0] div_q, div_d;
  logic        busy_q, busy_d;

  function automatic logic [1:0] hi_class(input logic [2:0] v);
    if (v[2])      return 2'd3;
    else if (v[1]) return 2'd2;
    else if (v[0]) return 2'd1;
    else           return 2'd0;
  endfunction

  function automatic logic [7:0] first_of(input logic [1:0] c);
    case (c)
      2'd1:    return PADDLE_FIRST;
      2'd2:    return BORDER_FIRST;
      2'd3:    return WIN_FIRST;
      default: return 8'd0;
    endcase
  endfunction

  function automatic logic [7:0] last_of(input logic [1:0] c);
    case (c)
      2'd1:    return PADDLE_LAST;
      2'd2:    return BORDER_LAST;
      2'd3:    return WIN_LAST;
      default: return 8'd0;
    endcase
  endfunction

  function automatic logic [2:0] class_bit(input logic [1:0] c);
    case (c)
      2'd1:    return 3'b001;
      2'd2:    return 3'b010;
      2'd3:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  logic [2:0]  req;
  logic [2:0]  cand;
  logic [1:0]  hreq;
  logic [1:0]  sel;
  logic        adv;

  assign req  = {win_req, border_req, paddle_req};
  assign hreq = hi_class(req);
  assign adv  = (div_q == (BEAT_DIV - 32'd1));

  // next-state: mute first, then start/preempt/restart, then beat advance
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    act_d   = act_q;
    pend_d  = pend_q;
    div_d   = div_q;
    cand    = 3'b000;
    sel     = 2'd0;
    if (mute) begin
      state_d = IDLE;
      beat_d  = 8'd0;
      act_d   = 2'd0;
      pend_d  = 3'b000;
      div_d   = 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          cand  = req | pend_q;
          div_d = 32'd0;
          if (cand != 3'b000) begin
            sel     = hi_class(cand);
            state_d = PLAY;
            beat_d  = first_of(sel);
            act_d   = sel;
            pend_d  = cand & ~class_bit(sel);
          end
        end
        default: begin
          cand  = pend_q | req;
          div_d = adv ? 32'd0 : div_q + 32'd1;
          if (hreq != 2'd0 && hreq >= act_q) begin
            // higher class preempts (old effect dropped); same class restarts
            sel    = hreq;
            beat_d = first_of(sel);
            act_d  = sel;
            div_d  = 32'd0;
            pend_d = cand & ~class_bit(sel);
          end else begin
            // lower-priority requests just latch as pending
            pend_d = cand;
            if (adv) begin
              if (beat_q < last_of(act_q)) begin
                beat_d = beat_q + 8'd1;
              end else if (cand != 3'b000) begin
                sel    = hi_class(cand);
                beat_d = first_of(sel);
                act_d  = sel;
                pend_d = cand & ~class_bit(sel);
              end else begin
                state_d = IDLE;
                beat_d  = 8'd0;
                act_d   = 2'd0;
                pend_d  = 3'b000;
              end
            end
          end
        end
      endcase
    end
    busy_d = (state_d == PLAY);
  end

  // state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      beat_q  <= 8'd0;
      act_q   <= 2'd0;
      pend_q  <= 3'b000;
      div_q   <= 32'd0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      act_q   <= act_d;
      pend_q  <= pend_d;
      div_q   <= div_d;
      busy_q  <= busy_d;
    end
  end

  assign beat_num   = beat_q;
  assign busy       = busy_q;
  assign active_sfx = act_q;

endmodule

// File: tb/tb_sfx_sequencer.sv
// Directed bench for sfx_sequencer with BEAT_DIV=4. Stimulus drives inputs
// on the falling edge and queues the outputs expected after the next rising
// edge; a monitor pops one entry per cycle and compares.
module tb_sfx_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       paddle_req, border_req, win_req, mute;
  logic [7:0] beat_num;
  logic       busy;
  logic [1:0] active_sfx;

  always #5 clk = ~clk;

  sfx_sequencer #(.BEAT_DIV(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .paddle_req (paddle_req),
    .border_req (border_req),
    .win_req    (win_req),
    .mute       (mute),
    .beat_num   (beat_num),
    .busy       (busy),
    .active_sfx (active_sfx)
  );

  typedef struct {
    logic [7:0] beat;
    logic       busy;
    logic [1:0] act;
    string      tag;
  } exp_t;

  exp_t  expq[$];
  exp_t  mon_e;
  int    checks = 0;
  int    errors = 0;
  string cur_tag = "reset";

  // monitor: one expected entry per rising edge, sampled 1 time unit later
  always @(posedge clk) begin
    #1;
    if (expq.size() > 0) begin
      mon_e = expq.pop_front();
      checks++;
      if (beat_num !== mon_e.beat || busy !== mon_e.busy || active_sfx !== mon_e.act) begin
        errors++;
        $display("FAIL %s: got beat=%0d busy=%0b act=%0d want beat=%0d busy=%0b act=%0d",
                 mon_e.tag, beat_num, busy, active_sfx, mon_e.beat, mon_e.busy, mon_e.act);
      end
    end
  end

  task automatic cyc(input logic p, input logic b, input logic w, input logic m,
                     input logic [7:0] eb, input logic ebusy, input logic [1:0] ea);
    exp_t e;
    @(negedge clk);
    paddle_req = p;
    border_req = b;
    win_req    = w;
    mute       = m;
    e.beat = eb; e.busy = ebusy; e.act = ea; e.tag = cur_tag;
    expq.push_back(e);
  endtask

  task automatic hold(input logic [7:0] eb, input logic ebusy, input logic [1:0] ea, input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, eb, ebusy, ea);
  endtask

  // expect beats first..last of one effect; first held first_n cycles, rest 4
  task automatic run_fx(input logic [7:0] first, input logic [7:0] last,
                        input logic [1:0] act, input int first_n);
    hold(first, 1'b1, act, first_n);
    for (int b = int'(first) + 1; b <= int'(last); b++) hold(8'(b), 1'b1, act, 4);
  endtask

  task automatic drain();
    int n = 0;
    while (expq.size() > 0 && n < 200) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (expq.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_%s: got %0d entries left want 0", cur_tag, expq.size());
      expq.delete();
    end
  endtask

  task automatic chk_zero(input string tag);
    checks++;
    if (beat_num !== 8'd0 || busy !== 1'b0 || active_sfx !== 2'd0) begin
      errors++;
      $display("FAIL %s: got beat=%0d busy=%0b act=%0d want beat=0 busy=0 act=0",
               tag, beat_num, busy, active_sfx);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    paddle_req = 1'b0; border_req = 1'b0; win_req = 1'b0; mute = 1'b0;
    #3;
    chk_zero("reset_state");
    @(negedge clk);
    rst_n = 1'b1;

    // single paddle effect: 1..5, 4 cycles each, then silence
    cur_tag = "paddle_solo";
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'd1, 1'b1, 2'd1);
    run_fx(8'd1, 8'd5, 2'd1, 3);
    hold(8'd0, 1'b0, 2'd0, 3);

    // win preempts paddle during beat 2; paddle is not resumed
    cur_tag = "win_preempt";
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'd1, 1'b1, 2'd1);
    hold(8'd1, 1'b1, 2'd1, 3);
    hold(8'd2, 1'b1, 2'd1, 2);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'd8, 1'b1, 2'd3);
    run_fx(8'd8, 8'd13, 2'd3, 3);
    hold(8'd0, 1'b0, 2'd0, 3);

    // border+paddle pend during win beat 9, then play in priority order
    cur_tag = "pend_chain";
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'd8, 1'b1, 2'd3);
    hold(8'd8, 1'b1, 2'd3, 3);
    hold(8'd9, 1'b1, 2'd3, 1);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'd9, 1'b1, 2'd3);
    hold(8'd9, 1'b1, 2'd3, 2);
    run_fx(8'd10, 8'd13, 2'd3, 4);
    run_fx(8'd6, 8'd7, 2'd2, 4);
    run_fx(8'd1, 8'd5, 2'd1, 4);
    hold(8'd0, 1'b0, 2'd0, 3);

    // all three requests in one idle cycle
    cur_tag = "simul_idle";
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 8'd8, 1'b1, 2'd3);
    run_fx(8'd8, 8'd13, 2'd3, 3);
    run_fx(8'd6, 8'd7, 2'd2, 4);
    run_fx(8'd1, 8'd5, 2'd1, 4);
    hold(8'd0, 1'b0, 2'd0, 3);

    // same-class request restarts border at 6
    cur_tag = "border_restart";
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'd6, 1'b1, 2'd2);
    hold(8'd6, 1'b1, 2'd2, 3);
    hold(8'd7, 1'b1, 2'd2, 1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'd6, 1'b1, 2'd2);
    hold(8'd6, 1'b1, 2'd2, 3);
    hold(8'd7, 1'b1, 2'd2, 4);
    hold(8'd0, 1'b0, 2'd0, 3);

    // lower request coinciding with the final-beat advance starts at once
    cur_tag = "final_beat_req";
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'd6, 1'b1, 2'd2);
    hold(8'd6, 1'b1, 2'd2, 3);
    hold(8'd7, 1'b1, 2'd2, 4);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'd1, 1'b1, 2'd1);
    run_fx(8'd1, 8'd5, 2'd1, 3);
    hold(8'd0, 1'b0, 2'd0, 3);

    // mute mid-win with paddle pending; muted request ignored; no replay
    cur_tag = "mute";
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'd8, 1'b1, 2'd3);
    hold(8'd8, 1'b1, 2'd3, 3);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'd9, 1'b1, 2'd3);
    hold(8'd9, 1'b1, 2'd3, 1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 2'd0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 2'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 2'd0);
    hold(8'd0, 1'b0, 2'd0, 10);

    // asynchronous reset mid-effect clears outputs without a clock edge
    cur_tag = "async_reset";
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'd8, 1'b1, 2'd3);
    hold(8'd8, 1'b1, 2'd3, 2);
    drain();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_busy: got busy=%0b want 1", busy);
    end
    rst_n = 1'b0;
    #1;
    chk_zero("async_reset_now");
    @(negedge clk);
    rst_n = 1'b1;
    cur_tag = "post_reset";
    hold(8'd0, 1'b0, 2'd0, 3);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish before 200000");
    $fatal(1);
  end

endmodule
